// File: rtl/adsr_mixer_pkg.sv
// adsr_mixer_pkg
//   Shared types and helpers for the ADSR voice mixer.
//   - adsr_state_t : per-voice envelope state
//   - seq_state_t  : mix-round sequencer state
//   - CFG_*        : configuration field selectors for cfg_field_i
//   - saturate()   : clamp a wide signed value to a signed width
package adsr_mixer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } adsr_state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_OUT
  } seq_state_t;

  localparam logic [2:0] CFG_ATTACK_STEP      = 3'd0;
  localparam logic [2:0] CFG_DECAY_STEP       = 3'd1;
  localparam logic [2:0] CFG_RELEASE_STEP     = 3'd2;
  localparam logic [2:0] CFG_SUSTAIN_DURATION = 3'd3;
  localparam logic [2:0] CFG_ATTACK_LEVEL     = 3'd4;
  localparam logic [2:0] CFG_SUSTAIN_LEVEL    = 3'd5;
  localparam logic [2:0] CFG_STATIC_GAIN      = 3'd6;

  // Clamp value to the range of a signed number of 'width' bits.
  // The caller keeps the low 'width' bits of the result.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int unsigned       width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) return max_v;
    if (value < min_v) return min_v;
    return value;
  endfunction

endpackage

// File: rtl/adsr_envelope_step.sv
// adsr_envelope_step
//   Combinational single-step ADSR update, shared by all voices of the mixer.
//   Pending note events are applied first, then the resulting state's action.
// Ports:
//   state, level, cnt        : current voice envelope registers
//   attack_step .. sustain_level, sustain_duration : voice configuration
//   note_on, note_off        : pending events (note_on has priority)
//   next_state, next_level, next_cnt : updated envelope registers
module adsr_envelope_step
  import adsr_mixer_pkg::*;
#(
  parameter int LEVEL_WIDTH = 32
) (
  input  adsr_state_t            state,
  input  logic [LEVEL_WIDTH-1:0] level,
  input  logic [LEVEL_WIDTH-1:0] cnt,
  input  logic [LEVEL_WIDTH-1:0] attack_step,
  input  logic [LEVEL_WIDTH-1:0] decay_step,
  input  logic [LEVEL_WIDTH-1:0] release_step,
  input  logic [LEVEL_WIDTH-1:0] sustain_duration,
  input  logic [LEVEL_WIDTH-1:0] attack_level,
  input  logic [LEVEL_WIDTH-1:0] sustain_level,
  input  logic                   note_on,
  input  logic                   note_off,
  output adsr_state_t            next_state,
  output logic [LEVEL_WIDTH-1:0] next_level,
  output logic [LEVEL_WIDTH-1:0] next_cnt
);

  adsr_state_t            work_state;
  logic [LEVEL_WIDTH:0]   attack_sum;
  logic [LEVEL_WIDTH-1:0] attack_capped;

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    work_state    = state;
    next_state    = state;
    next_level    = level;
    next_cnt      = cnt;
    attack_sum    = '0;
    attack_capped = '0;

    // Events first: retrigger keeps the current level, release only from an active note.
    if (note_on) begin
      work_state = ATTACK;
    end else if (note_off && (state inside {ATTACK, DECAY, SUSTAIN})) begin
      work_state = RELEASE;
    end
    next_state = work_state;

    case (work_state)
      IDLE: begin
        next_level = '0;
      end
      ATTACK: begin
        attack_sum    = {1'b0, level} + {1'b0, attack_step};
        attack_capped = attack_sum[LEVEL_WIDTH] ? '1 : attack_sum[LEVEL_WIDTH-1:0];
        if (attack_capped >= attack_level) begin
          next_level = attack_level;
          next_state = DECAY;
        end else begin
          next_level = attack_capped;
        end
      end
      DECAY: begin
        if ((decay_step > level) || ((level - decay_step) <= sustain_level)) begin
          next_level = sustain_level;
          next_state = SUSTAIN;
          next_cnt   = sustain_duration;
        end else begin
          next_level = level - decay_step;
        end
      end
      SUSTAIN: begin
        // A zero duration holds until note_off; cnt<=1 also covers a duration
        // rewritten while the voice was already sustaining.
        if (sustain_duration != '0) begin
          if (cnt <= LEVEL_WIDTH'(1)) begin
            next_cnt   = '0;
            next_state = RELEASE;
          end else begin
            next_cnt = cnt - LEVEL_WIDTH'(1);
          end
        end
      end
      RELEASE: begin
        if (release_step >= level) begin
          next_level = '0;
          next_state = IDLE;
        end else begin
          next_level = level - release_step;
        end
      end
      default: begin
        next_state = IDLE;
        next_level = '0;
      end
    endcase
  end

endmodule

// File: rtl/adsr_voice_mixer.sv
// adsr_voice_mixer
//   Time-multiplexed N-voice ADSR envelope and gain mixer. Each accepted
//   sample tick runs one round: every voice's envelope steps once, its sample
//   is scaled by its gain, and the saturated sum is presented with a strobe.
// Ports:
//   clk_i, rst_n_i        : clock, synchronous active-low reset
//   sample_tick_i         : start a mix round
//   voice_sample_i        : packed signed per-voice samples (voice v at [v*SW +: SW])
//   note_on_i, note_off_i : per-voice trigger / release pulses
//   env_enable_i          : per-voice 1 = envelope gain, 0 = static gain
//   cfg_write_i, cfg_voice_i, cfg_field_i, cfg_data_i : configuration write port
//   voice_idle_o          : per-voice envelope IDLE flag
//   busy_o                : round in progress
//   mixed_sample_o        : last mixed sample, held between rounds
//   mixed_valid_o         : one-cycle strobe with each new mixed sample
//   tick_miss_o           : tick arrived while busy and was dropped
module adsr_voice_mixer
  import adsr_mixer_pkg::*;
#(
  parameter int VOICES       = 8,
  parameter int SAMPLE_WIDTH = 16,
  parameter int LEVEL_WIDTH  = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             sample_tick_i,
  input  logic [VOICES*SAMPLE_WIDTH-1:0]   voice_sample_i,
  input  logic [VOICES-1:0]                note_on_i,
  input  logic [VOICES-1:0]                note_off_i,
  input  logic [VOICES-1:0]                env_enable_i,
  input  logic                             cfg_write_i,
  input  logic [$clog2(VOICES)-1:0]        cfg_voice_i,
  input  logic [2:0]                       cfg_field_i,
  input  logic [31:0]                      cfg_data_i,
  output logic [VOICES-1:0]                voice_idle_o,
  output logic                             busy_o,
  output logic [SAMPLE_WIDTH-1:0]          mixed_sample_o,
  output logic                             mixed_valid_o,
  output logic                             tick_miss_o
);

  localparam int IDX_W    = $clog2(VOICES);
  localparam int PROD_W   = SAMPLE_WIDTH + 17;
  localparam int SCALED_W = SAMPLE_WIDTH + 2;
  localparam int ACC_W    = SAMPLE_WIDTH + $clog2(VOICES) + 2;

  // Per-voice configuration and envelope state
  logic [LEVEL_WIDTH-1:0] attack_step_q      [VOICES];
  logic [LEVEL_WIDTH-1:0] decay_step_q       [VOICES];
  logic [LEVEL_WIDTH-1:0] release_step_q     [VOICES];
  logic [LEVEL_WIDTH-1:0] sustain_duration_q [VOICES];
  logic [LEVEL_WIDTH-1:0] attack_level_q     [VOICES];
  logic [LEVEL_WIDTH-1:0] sustain_level_q    [VOICES];
  logic [15:0]            static_gain_q      [VOICES];
  adsr_state_t            env_state_q        [VOICES];
  logic [LEVEL_WIDTH-1:0] level_q            [VOICES];
  logic [LEVEL_WIDTH-1:0] cnt_q              [VOICES];
  logic [VOICES-1:0]      pend_on_q;
  logic [VOICES-1:0]      pend_off_q;

  // Sequencer
  seq_state_t                 state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [SAMPLE_WIDTH-1:0]    mixed_q, mixed_d;
  logic signed [SCALED_W-1:0] prod_q, prod_d;
  logic                       run;

  // Shared datapath for the voice selected by idx_q
  logic                       eff_on, eff_off;
  adsr_state_t                step_state;
  logic [LEVEL_WIDTH-1:0]     step_level, step_cnt;
  logic [15:0]                gain;
  logic signed [16:0]         gain_s;
  logic signed [SAMPLE_WIDTH-1:0] cur_sample;
  logic signed [PROD_W-1:0]   prod_full;
  logic [LEVEL_WIDTH-1:0]     cfg_level;

  assign cfg_level = LEVEL_WIDTH'(cfg_data_i);

  // Events arriving in the voice's own processing cycle are used directly.
  assign eff_on  = pend_on_q[idx_q] | note_on_i[idx_q];
  assign eff_off = (pend_off_q[idx_q] | note_off_i[idx_q]) & ~eff_on;

  adsr_envelope_step #(
    .LEVEL_WIDTH (LEVEL_WIDTH)
  ) u_env_step (
    .state            (env_state_q[idx_q]),
    .level            (level_q[idx_q]),
    .cnt              (cnt_q[idx_q]),
    .attack_step      (attack_step_q[idx_q]),
    .decay_step       (decay_step_q[idx_q]),
    .release_step     (release_step_q[idx_q]),
    .sustain_duration (sustain_duration_q[idx_q]),
    .attack_level     (attack_level_q[idx_q]),
    .sustain_level    (sustain_level_q[idx_q]),
    .note_on          (eff_on),
    .note_off         (eff_off),
    .next_state       (step_state),
    .next_level       (step_level),
    .next_cnt         (step_cnt)
  );

  // Gain uses the freshly stepped level so a note is heard on its first round.
  assign gain       = env_enable_i[idx_q] ? step_level[LEVEL_WIDTH-1 -: 16] : static_gain_q[idx_q];
  assign gain_s     = signed'({1'b0, gain});
  assign cur_sample = voice_sample_i[idx_q*SAMPLE_WIDTH +: SAMPLE_WIDTH];
  // Operands are widened first so the product is computed at full width.
  assign prod_full  = PROD_W'(cur_sample) * PROD_W'(gain_s);
  assign prod_d     = SCALED_W'(prod_full >>> 15);

  assign run = (state_q == S_RUN);

  // Sequencer next-state and outputs
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    mixed_d       = mixed_q;
    busy_o        = (state_q != S_IDLE);
    mixed_valid_o = (state_q == S_OUT);
    tick_miss_o   = sample_tick_i && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (sample_tick_i) begin
          state_d = S_RUN;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      S_RUN: begin
        // prod_q holds the previous voice's product; nothing valid yet at voice 0.
        if (idx_q != '0) acc_d = acc_q + ACC_W'(prod_q);
        if (idx_q == IDX_W'(VOICES - 1)) begin
          state_d = S_DRAIN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DRAIN: begin
        acc_d   = acc_q + ACC_W'(prod_q);
        mixed_d = SAMPLE_WIDTH'(saturate(64'(acc_d), SAMPLE_WIDTH));
        state_d = S_OUT;
      end
      S_OUT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mixed_sample_o = mixed_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      mixed_q <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      mixed_q <= mixed_d;
      if (run) prod_q <= prod_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      // NOTE: these per-voice arrays are reset explicitly because software
      // relies on a zeroed configuration; this keeps them in flops, not RAM.
      for (int v = 0; v < VOICES; v++) begin
        attack_step_q[v]      <= '0;
        decay_step_q[v]       <= '0;
        release_step_q[v]     <= '0;
        sustain_duration_q[v] <= '0;
        attack_level_q[v]     <= '0;
        sustain_level_q[v]    <= '0;
        static_gain_q[v]      <= '0;
        env_state_q[v]        <= IDLE;
        level_q[v]            <= '0;
        cnt_q[v]              <= '0;
      end
      pend_on_q  <= '0;
      pend_off_q <= '0;
    end else begin
      if (cfg_write_i && (32'(cfg_voice_i) < VOICES)) begin
        case (cfg_field_i)
          CFG_ATTACK_STEP:      attack_step_q[cfg_voice_i]      <= cfg_level;
          CFG_DECAY_STEP:       decay_step_q[cfg_voice_i]       <= cfg_level;
          CFG_RELEASE_STEP:     release_step_q[cfg_voice_i]     <= cfg_level;
          CFG_SUSTAIN_DURATION: sustain_duration_q[cfg_voice_i] <= cfg_level;
          CFG_ATTACK_LEVEL:     attack_level_q[cfg_voice_i]     <= cfg_level;
          CFG_SUSTAIN_LEVEL:    sustain_level_q[cfg_voice_i]    <= cfg_level;
          CFG_STATIC_GAIN:      static_gain_q[cfg_voice_i]      <= cfg_data_i[15:0];
          default: ;
        endcase
      end

      if (run) begin
        env_state_q[idx_q] <= step_state;
        level_q[idx_q]     <= step_level;
        cnt_q[idx_q]       <= step_cnt;
      end

      // Pending events: consumed by processing, note_on dominates note_off.
      for (int v = 0; v < VOICES; v++) begin
        if (run && (32'(idx_q) == v)) begin
          pend_on_q[v]  <= 1'b0;
          pend_off_q[v] <= 1'b0;
        end else if (note_on_i[v]) begin
          pend_on_q[v]  <= 1'b1;
          pend_off_q[v] <= 1'b0;
        end else if (note_off_i[v] && !pend_on_q[v]) begin
          pend_off_q[v] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    voice_idle_o = '0;
    for (int v = 0; v < VOICES; v++) begin
      voice_idle_o[v] = (env_state_q[v] == IDLE);
    end
  end

endmodule

// File: tb/tb_adsr_voice_mixer.sv
// tb_adsr_voice_mixer
//   Directed self-checking bench for adsr_voice_mixer with VOICES=4.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge.
module tb_adsr_voice_mixer;

  localparam int VOICES = 4;
  localparam int SW     = 16;
  localparam int LW     = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 sample_tick;
  logic [VOICES*SW-1:0] voice_sample;
  logic [VOICES-1:0]    note_on;
  logic [VOICES-1:0]    note_off;
  logic [VOICES-1:0]    env_enable;
  logic                 cfg_write;
  logic [1:0]           cfg_voice;
  logic [2:0]           cfg_field;
  logic [31:0]          cfg_data;
  logic [VOICES-1:0]    voice_idle;
  logic                 busy;
  logic [SW-1:0]        mixed_sample;
  logic                 mixed_valid;
  logic                 tick_miss;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  adsr_voice_mixer #(
    .VOICES       (VOICES),
    .SAMPLE_WIDTH (SW),
    .LEVEL_WIDTH  (LW)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .sample_tick_i  (sample_tick),
    .voice_sample_i (voice_sample),
    .note_on_i      (note_on),
    .note_off_i     (note_off),
    .env_enable_i   (env_enable),
    .cfg_write_i    (cfg_write),
    .cfg_voice_i    (cfg_voice),
    .cfg_field_i    (cfg_field),
    .cfg_data_i     (cfg_data),
    .voice_idle_o   (voice_idle),
    .busy_o         (busy),
    .mixed_sample_o (mixed_sample),
    .mixed_valid_o  (mixed_valid),
    .tick_miss_o    (tick_miss)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    sample_tick  = 1'b0;
    note_on      = '0;
    note_off     = '0;
    env_enable   = '0;
    cfg_write    = 1'b0;
    cfg_voice    = '0;
    cfg_field    = '0;
    cfg_data     = '0;
    voice_sample = '0;
    repeat (3) next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic cfg(input int v, input int f, input logic [31:0] d);
    cfg_write = 1'b1;
    cfg_voice = 2'(v);
    cfg_field = 3'(f);
    cfg_data  = d;
    next_cycle();
    cfg_write = 1'b0;
  endtask

  task automatic set_samples(input logic [15:0] s0, input logic [15:0] s1,
                             input logic [15:0] s2, input logic [15:0] s3);
    voice_sample = {s3, s2, s1, s0};
  endtask

  // One tick, then wait (bounded) for the strobe; checks latency, value, no miss.
  task automatic run_round(input string tag, input logic [15:0] exp);
    logic [15:0] s;
    int          lat;
    logic        miss;
    s   = '0;
    lat = -1;
    miss = 1'b0;
    sample_tick = 1'b1;
    next_cycle();
    sample_tick = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (tick_miss) miss = 1'b1;
      if (mixed_valid && lat < 0) begin
        lat = c;
        s   = mixed_sample;
      end
      next_cycle();
      if (lat >= 0) break;
    end
    check({tag, " latency"}, 64'(lat), 64'(VOICES + 2));
    check({tag, " sample"}, 64'(s), 64'(exp));
    check({tag, " tick_miss"}, 64'(miss), 64'd0);
  endtask

  logic [15:0] env_gains [10];
  logic [15:0] env_exp;
  int          valid_cnt, miss_cnt, valid_at, miss_at;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    env_gains = '{16'h4000, 16'h8000, 16'h7000, 16'h6000, 16'h6000,
                  16'h6000, 16'h6000, 16'h4000, 16'h2000, 16'h0000};

    // Reset state
    do_reset();
    @(negedge clk);
    check("reset voice_idle", 64'(voice_idle), 64'hF);
    check("reset busy", 64'(busy), 64'd0);
    check("reset mixed_valid", 64'(mixed_valid), 64'd0);
    check("reset mixed_sample", 64'(mixed_sample), 64'd0);
    check("reset tick_miss", 64'(tick_miss), 64'd0);
    next_cycle();

    // Ten back-to-back rounds with all gains zero
    set_samples(16'h1234, 16'h1234, 16'h1234, 16'h1234);
    for (int i = 0; i < 10; i++) run_round($sformatf("zero round %0d", i), 16'h0000);

    // Static gain on voice 0 only
    set_samples(16'h1000, 16'h7777, 16'h7777, 16'h7777);
    cfg(0, 6, 32'h0000_8000);
    run_round("static 0x8000", 16'h1000);
    cfg(0, 6, 32'h0000_4000);
    run_round("static 0x4000", 16'h0800);

    // Full ADSR trace on voice 1
    cfg(0, 6, 32'h0000_0000);
    cfg(1, 0, 32'h4000_0000);
    cfg(1, 4, 32'h8000_0000);
    cfg(1, 1, 32'h1000_0000);
    cfg(1, 5, 32'h6000_0000);
    cfg(1, 3, 32'd3);
    cfg(1, 2, 32'h2000_0000);
    env_enable = 4'b0010;
    set_samples(16'h1000, 16'h2000, 16'h5555, 16'h5555);
    note_on = 4'b0010;
    next_cycle();
    note_on = '0;
    for (int i = 0; i < 10; i++) begin
      env_exp = 16'((32'(env_gains[i]) * 32'h2000) >> 15);
      run_round($sformatf("env tick %0d", i), env_exp);
      if (i == 0) begin
        @(negedge clk);
        check("env voice1 active", 64'(voice_idle[1]), 64'd0);
        next_cycle();
      end
    end
    @(negedge clk);
    check("env voice1 idle after release", 64'(voice_idle[1]), 64'd1);
    next_cycle();

    // Saturation both ways
    env_enable = '0;
    for (int v = 0; v < VOICES; v++) cfg(v, 6, 32'h0000_8000);
    set_samples(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    run_round("sat positive", 16'h7FFF);
    set_samples(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    run_round("sat negative", 16'h8000);

    // Tick repeated two cycles after an accepted tick
    valid_cnt = 0;
    miss_cnt  = 0;
    valid_at  = -1;
    miss_at   = -1;
    for (int c = 0; c <= 20; c++) begin
      sample_tick = (c == 0 || c == 2);
      @(negedge clk);
      if (tick_miss) begin
        miss_cnt++;
        if (miss_at < 0) miss_at = c;
      end
      if (mixed_valid) begin
        valid_cnt++;
        if (valid_at < 0) valid_at = c;
      end
      next_cycle();
    end
    sample_tick = 1'b0;
    check("miss pulse count", 64'(miss_cnt), 64'd1);
    check("miss pulse cycle", 64'(miss_at), 64'd2);
    check("miss valid count", 64'(valid_cnt), 64'd1);
    check("miss valid cycle", 64'(valid_at), 64'(VOICES + 2));
    check("miss round value", 64'(mixed_sample), 64'h8000);

    // note_on and note_off together on an idle voice: note_on wins
    do_reset();
    cfg(2, 0, 32'h1000_0000);
    cfg(2, 4, 32'hFFFF_FFFF);
    env_enable = 4'b0100;
    set_samples(16'h1234, 16'h1234, 16'h4000, 16'h1234);
    note_on  = 4'b0100;
    note_off = 4'b0100;
    next_cycle();
    note_on  = '0;
    note_off = '0;
    @(negedge clk);
    check("on+off pending still idle", 64'(voice_idle), 64'hF);
    next_cycle();
    run_round("on+off attack", 16'h0800);
    @(negedge clk);
    check("on+off attack entered", 64'(voice_idle), 64'hB);
    next_cycle();

    // Reset asserted two cycles into a round
    sample_tick = 1'b1;
    next_cycle();
    sample_tick = 1'b0;
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset mixed_valid", 64'(mixed_valid), 64'd0);
    check("midreset mixed_sample", 64'(mixed_sample), 64'd0);
    check("midreset voice_idle", 64'(voice_idle), 64'hF);
    check("midreset tick_miss", 64'(tick_miss), 64'd0);
    next_cycle();
    valid_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mixed_valid) valid_cnt++;
      next_cycle();
    end
    check("midreset no strobe", 64'(valid_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
